multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Multi-cycle signed 32-bit multiply/divide execute unit.
- Operands come straight from the register file read ports (data_readRegA/data_readRegB); the result is returned to the writeback path, which writes it into the register file.
- Iterative datapath: one partial-product or quotient bit per cycle.
- Fixed latency, one-cycle result-ready pulse.

Parameters:
- WIDTH, 32: operand/result width; only 32 is verified.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only on a start edge.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only on a start edge.
- ctrl_MULT  in  1  start-multiply request, level-sampled each edge.
- ctrl_DIV  in  1  start-divide request, level-sampled each edge.
- data_result  out  WIDTH  product low word or quotient; held until the next start.
- data_exception  out  1  overflow / divide-by-zero flag; valid with data_resultRDY, held like data_result.
- data_resultRDY  out  1  one-cycle pulse: data_result and data_exception valid.
- busy  out  1  operation in progress.

Behaviour:
- Reset: ctrl_reset is sampled at the rising edge and wins over everything else.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0, FSM=IDLE.
  - Any in-flight operation is dropped; no RDY pulse is ever issued for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a start edge.
  - RUN runs for exactly WIDTH iterations (counter 0..WIDTH-1), then -> DONE.
  - DONE lasts one cycle, then -> IDLE (or -> RUN if a start is sampled in DONE).
- Start edge: a rising edge with ctrl_MULT|ctrl_DIV=1 and ctrl_reset=0.
  - Operands and opcode are latched; the counter is cleared; busy=1 from this edge.
- Opcode priority: if ctrl_MULT and ctrl_DIV are both 1, multiply wins.
- Start while busy (RUN or DONE): aborts the current operation and restarts with the new operands.
  - The aborted operation never produces an RDY pulse.
  - The latency count restarts from the new start edge.
- Latency: start at edge E0 -> data_resultRDY=1 during the cycle after edge E0+WIDTH+1 (edge 33 for WIDTH=32).
  - RDY deasserts at edge E0+WIDTH+2.
  - busy=1 from E0 through E0+WIDTH+1; busy=0 in the DONE cycle.
- data_result and data_exception update only at the DONE-entry edge; they are stable outside that edge.
- Multiply:
  - Signed two's-complement, radix-2 Booth, 2*WIDTH-bit product register.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff the full product is not representable in signed WIDTH bits, i.e. product[2W-1:W-1] is not all-0 or all-1.
- Divide:
  - Signed, non-restoring on magnitudes; quotient truncates toward zero; remainder is discarded.
  - Quotient is negated iff the operand signs differ.
  - Divisor=0: data_result=0, data_exception=1; full latency still applies.
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - Dividend=0 with nonzero divisor: result 0, no exception.
- Operand inputs may change freely after the start edge without affecting the result.
- No back-pressure: the consumer must capture the result in the RDY cycle; the value remains readable until the next start.

Test Plan:
- Reset asserted 2 cycles -> all outputs 0, busy=0. MULT 7 x 0xFFFFFFFA -> RDY exactly 33 edges after start, result 0xFFFFFFD6, exc 0, RDY width 1 cycle.
- MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc 1. MULT 0x7FFFFFFF x 1 -> 0x7FFFFFFF, exc 0.
- DIV 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2 (-14), exc 0. DIV 100 / 0xFFFFFFF9 -> 0xFFFFFFF2, exc 0.
- DIV 5 / 0 -> result 0, exc 1 at edge 33. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exc 1.
- Restart: MULT 3x4, then at edge 10 DIV 20/4 -> exactly one RDY pulse, at edge 10+33, result 5; no pulse at edge 33.
- Reset at edge 15 of a MULT -> no RDY, outputs 0. Next MULT 2x3 -> 6. Both ctrl_MULT and ctrl_DIV high with 6, 3 -> 18.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: radix-2 Booth multiply and
// non-restoring magnitude divide, one bit per cycle, fixed latency.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic                    start;
    logic                    last;
    logic                    finish;
    logic [CNT_W-1:0]        cnt_q;
    logic                    op_div_q;
    logic                    neg_q;
    logic                    dvz_q;
    logic [WIDTH-1:0]        a_q;
    logic signed [WIDTH+1:0] hi_q, hi_d;
    logic [WIDTH-1:0]        lo_q, lo_d;
    logic                    ext_q, ext_d;
    logic signed [WIDTH+1:0] a_ext, d_ext, sh, sum;
    logic [2*WIDTH-1:0]      product;
    logic [WIDTH:0]          div_out;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // Product fits in WIDTH signed bits only if its top WIDTH+1 bits are a pure sign extension.
    function automatic logic mult_ovf(input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] top;
        top = p[2*WIDTH-1:WIDTH-1];
        return !((&top) || (~|top));
    endfunction

    function automatic logic [WIDTH:0] div_fix(input logic [WIDTH-1:0] q,
                                               input logic neg, input logic dvz);
        logic [WIDTH-1:0] res;
        logic             exc;
        if (dvz) begin
            res = '0;
            exc = 1'b1;
        end else begin
            res = neg ? (~q + 1'b1) : q;
            exc = !neg && q[WIDTH-1];
        end
        return {exc, res};
    endfunction

    assign start  = ctrl_MULT | ctrl_DIV;
    assign last   = (cnt_q == CNT_W'(WIDTH));
    assign finish = (state_q == RUN) && last && !start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (start) state_d = RUN; else if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};
    assign d_ext = {2'b00, a_q};

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        ext_d = ext_q;
        sh    = '0;
        sum   = hi_q;
        if (!op_div_q) begin
            case ({lo_q[0], ext_q})
                2'b01:   sum = hi_q + a_ext;
                2'b10:   sum = hi_q - a_ext;
                default: sum = hi_q;
            endcase
            hi_d  = sum >>> 1;
            lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            ext_d = lo_q[0];
        end else begin
            // Partial remainder sign picks add or subtract; no restore step needed.
            sh   = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
            sum  = hi_q[WIDTH+1] ? (sh + d_ext) : (sh - d_ext);
            hi_d = sum;
            lo_d = {lo_q[WIDTH-2:0], ~sum[WIDTH+1]};
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            op_div_q <= ~ctrl_MULT;
            cnt_q    <= '0;
            hi_q     <= '0;
            ext_q    <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dvz_q    <= (data_operandB == '0);
            if (ctrl_MULT) begin
                a_q  <= data_operandA;
                lo_q <= data_operandB;
            end else begin
                a_q  <= magnitude(data_operandB);
                lo_q <= magnitude(data_operandA);
            end
        end else if (state_q == RUN && !last) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            ext_q <= ext_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign product = {hi_q[WIDTH-1:0], lo_q};
    assign div_out = div_fix(lo_q, neg_q, dvz_q);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (finish) begin
            if (op_div_q) begin
                data_result    <= div_out[WIDTH-1:0];
                data_exception <= div_out[WIDTH];
            end else begin
                data_result    <= lo_q;
                data_exception <= mult_ovf(product);
            end
        end
    end

    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);

endmodule
